shift_reg_sequencer: RTL
========================

Name: shift_reg_sequencer

Overview:
Command-driven controller for the WIDTH-bit universal shift register datapath (mode select 00 hold, 01 shift right, 10 shift left, 11 parallel load).
- Accepts one command at a time over a valid/ready handshake: load, logical shift or rotate by a count.
- Drives the datapath's sel, p_in, serial_right and serial_left, and reads back q for rotate feedback.
- Signals completion with a one-cycle done pulse. Sits between a host or bus-side FSM and the register instance in the parent.

Parameters:
WIDTH, 4, datapath width (must match the register instance)
AMT_W, 3, width of the shift-count field (maximum count 2^AMT_W-1)

Ports:
clk  in  1  single clock, all state updates on posedge
rst  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  3  operation code (see package)
cmd_amt  in  AMT_W  shift/rotate count
cmd_data  in  WIDTH  parallel load value
cmd_fill  in  1  bit shifted in for logical shifts
abort  in  1  cancel the in-flight command
q  in  WIDTH  datapath register contents (feedback)
sel  out  2  datapath mode select
p_in  out  WIDTH  datapath parallel input
serial_right  out  1  datapath MSB-side serial input (right shift)
serial_left  out  1  datapath LSB-side serial input (left shift)
busy  out  1  command in progress (LOAD or SHIFT state)
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done on an illegal op

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all captured fields cleared.
  - While rst=0, all outputs are 0, including cmd_ready.
- Moore outputs are decoded from registered state and captured fields only. The exception is the serial bits in rotate mode, which take q directly; q is a register, so there is no combinational loop.
- IDLE:
  - Outputs: cmd_ready=1, sel=00.
  - Accept when cmd_valid=1 and abort=0. Capture op, amt, data and fill.
  - Next state by op:
    - LOAD goes to LOAD.
    - SHR/SHL/ROTR/ROTL with amt!=0 go to SHIFT with cnt=amt.
    - A shift op with amt=0 goes to DONE.
    - An illegal op goes to DONE with err flagged.
- LOAD: sel=11, p_in=captured data for exactly one cycle, then DONE.
- SHIFT:
  - Right ops use sel=01. serial_right = q[0] for ROTR, otherwise fill.
  - Left ops use sel=10. serial_left = q[WIDTH-1] for ROTL, otherwise fill.
  - The unused serial output is 0.
  - cnt decrements each cycle. When cnt==1, go to DONE; exactly amt shift cycles are issued.
  - amt is not reduced modulo WIDTH: rotating by WIDTH returns the original value, and a logical shift by ≥WIDTH yields all-fill.
- DONE: done=1 (err=1 if flagged), sel=00, cmd_ready=0, then IDLE.
- Latency, with the command accepted at edge N:
  - LOAD: sel=11 during cycle N+1; done in cycle N+2.
  - Shift by k: sel active in cycles N+1..N+k; done in cycle N+k+1.
  - amt=0 or illegal op: done in cycle N+1.
  - Minimum accept-to-accept spacing is LOAD 3 cycles, shift k+2.
- abort:
  - In LOAD or SHIFT: the next state is IDLE with no done.
  - The datapath operation of the cycle in which abort is sampled still takes effect, because sel is Moore.
  - Ignored in DONE.
  - In IDLE, abort blocks acceptance (abort wins over cmd_valid).
- Reset mid-operation: immediate return to IDLE, with no done pulse.
- p_in = captured data in all states; it is only significant when sel=11.

Decomposition:
- Package shift_seq_pkg:
  - opcodes OP_LOAD=0, OP_SHR=1, OP_SHL=2, OP_ROTR=3, OP_ROTL=4 (5–7 illegal)
  - state encoding IDLE=0, LOAD=1, SHIFT=2, DONE=3
  - SEL_HOLD=00, SEL_SHR=01, SEL_SHL=10, SEL_LOAD=11
- One natural sub-module: shift_down_counter (AMT_W-bit loadable down-counter with a "last" flag at value 1).
- The register datapath is instantiated by the parent, not inside this block.
- The bench instantiates both the register and this block with WIDTH=4.

Test Plan:
1. Hold rst=0 for 2 cycles with cmd_valid=1 → sel=00, cmd_ready=0, done=0, busy=0; q stays 0000, no command accepted.
2. LOAD data=1011 accepted at edge N → sel=11 in cycle N+1; q=1011 after it; done=1 only in cycle N+2; err=0.
3. From q=1011, ROTR amt=3 → q sequence 1101, 1110, 0111; done in cycle N+4. Then ROTL amt=4 → q returns to 0111.
4. From q=1011, SHL amt=2 fill=0 → 0110, then 1100, done. From q=0000, SHR amt=5 fill=1 → 1000, 1100, 1110, 1111, 1111.
5. From q=0000, SHR amt=5 fill=1, with abort=1 sampled in the 2nd shift cycle → q=1100; next cycle sel=00, busy=0, cmd_ready=1; no done.
6. Op=6 → done+err pulse at N+1, q unchanged. SHL amt=0 → done at N+1, err=0. Back-to-back valid commands are accepted only when cmd_ready=1, with no lost or duplicated commands.

Source files
------------

// File: rtl/shift_reg_sequencer_pkg.sv
// Shared encodings for the shift-register sequencer: opcodes, FSM states,
// datapath mode selects and small opcode classification helpers.
package shift_seq_pkg;

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_SHR  = 3'd1,
      OP_SHL  = 3'd2,
      OP_ROTR = 3'd3,
      OP_ROTL = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'b00,
      SEL_SHR  = 2'b01,
      SEL_SHL  = 2'b10,
      SEL_LOAD = 2'b11
   } sel_e;

   function automatic logic is_shift_op(logic [2:0] op);
      logic r;
      case (op)
         OP_SHR, OP_SHL, OP_ROTR, OP_ROTL: r = 1'b1;
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_right_op(logic [2:0] op);
      return (op == OP_SHR) || (op == OP_ROTR);
   endfunction

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command handshake between a host-side FSM and the shift-register sequencer.
interface shift_reg_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [AMT_W-1:0] cmd_amt;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_fill;
   logic             abort;

   modport master (
      output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill, abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill, abort,
      output cmd_ready
   );
endinterface

// File: rtl/shift_reg_sequencer_counter.sv
// Loadable down-counter tracking remaining shift cycles; last flags the
// final cycle (count == 1).
module shift_down_counter #(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [AMT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);
   logic [AMT_W-1:0] cnt_d, cnt_q;

   // NOTE: every variable written here gets its default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state updates use non-blocking assignment so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == AMT_W'(1));
endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for a universal shift register: turns load,
// shift and rotate commands into per-cycle mode selects and serial inputs.
module shift_reg_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   shift_reg_sequencer_if.slave  cmd,
   input  logic [WIDTH-1:0]      q,
   output logic [1:0]            sel,
   output logic [WIDTH-1:0]      p_in,
   output logic                  serial_right,
   output logic                  serial_left,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   state_e           state_d, state_q;
   logic [2:0]       op_d, op_q;
   logic [WIDTH-1:0] data_d, data_q;
   logic             fill_d, fill_q;
   logic             err_d, err_q;
   logic             cnt_load, cnt_dec, cnt_last;

   logic [1:0]       sel_c;
   logic             ready_c, sr_c, sl_c, busy_c, done_c, err_c;

   shift_down_counter #(.AMT_W(AMT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cmd.cmd_amt),
      .dec      (cnt_dec),
      .last     (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      fill_d   = fill_q;
      err_d    = err_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // abort outranks cmd_valid so a cancelled host never starts work
            if (cmd.cmd_valid && !cmd.abort) begin
               op_d   = cmd.cmd_op;
               data_d = cmd.cmd_data;
               fill_d = cmd.cmd_fill;
               err_d  = 1'b0;
               if (cmd.cmd_op == OP_LOAD) begin
                  state_d = ST_LOAD;
               end else if (is_shift_op(cmd.cmd_op)) begin
                  if (cmd.cmd_amt != '0) begin
                     state_d  = ST_SHIFT;
                     cnt_load = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            state_d = cmd.abort ? ST_IDLE : ST_DONE;
         end
         ST_SHIFT: begin
            cnt_dec = 1'b1;
            if (cmd.abort) begin
               state_d = ST_IDLE;
            end else if (cnt_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
      end
   end

   // Moore decode; only the rotate feedback bits look at q, which is itself a flop.
   always_comb begin
      sel_c   = SEL_HOLD;
      ready_c = 1'b0;
      sr_c    = 1'b0;
      sl_c    = 1'b0;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      err_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
         end
         ST_LOAD: begin
            sel_c  = SEL_LOAD;
            busy_c = 1'b1;
         end
         ST_SHIFT: begin
            busy_c = 1'b1;
            if (is_right_op(op_q)) begin
               sel_c = SEL_SHR;
               sr_c  = (op_q == OP_ROTR) ? q[0] : fill_q;
            end else begin
               sel_c = SEL_SHL;
               sl_c  = (op_q == OP_ROTL) ? q[WIDTH-1] : fill_q;
            end
         end
         ST_DONE: begin
            done_c = 1'b1;
            err_c  = err_q;
         end
         default: begin
            sel_c = SEL_HOLD;
         end
      endcase
   end

   // Reset is level-sensitive on the outputs so nothing leaks while rst is low.
   assign cmd.cmd_ready = rst & ready_c;
   assign sel           = rst ? sel_c : 2'b00;
   assign p_in          = rst ? data_q : '0;
   assign serial_right  = rst & sr_c;
   assign serial_left   = rst & sl_c;
   assign busy          = rst & busy_c;
   assign done          = rst & done_c;
   assign err           = rst & err_c;
endmodule
